// File: rtl/pdm_decimator_if.sv
// ---------------------------------------------------------------------------
// pdm_decimator_if
// Sample-stream bundle between the PDM decimator and the downstream sample
// path.
//   sample_out  : signed 8-bit recovered level
//   valid_out   : sample_out holds an unconsumed sample
//   ready_in    : downstream accepts (transfer on valid_out & ready_in)
//   overrun_out : one-cycle pulse when an unconsumed sample is overwritten
// Modports: master = decimator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pdm_decimator_if;
    logic signed [7:0] sample_out;
    logic              valid_out;
    logic              ready_in;
    logic              overrun_out;

    modport master (
        output sample_out,
        output valid_out,
        output overrun_out,
        input  ready_in
    );

    modport slave (
        input  sample_out,
        input  valid_out,
        input  overrun_out,
        output ready_in
    );
endinterface

// File: rtl/pdm_decimator.sv
// ---------------------------------------------------------------------------
// pdm_decimator
// Recovers signed 8-bit levels from a 1-bit PDM stream using a 2nd-order
// CIC decimator (ratio R = 2^LOG2_DECIM), scaling and saturation, and hands
// them out over a valid/ready stream.
//
// Ports:
//   clk_in    : system clock
//   rst_in    : asynchronous, active-high reset
//   pdm_in    : PDM bit (1 -> +1, 0 -> -1), sampled when tick_in = 1
//   tick_in   : one-cycle sample strobe
//   o_stream  : pdm_decimator_if.master (sample_out, valid_out, ready_in,
//               overrun_out)
//
// Optional build macro PDM_DC_BLOCK_EN: inserts a DC-blocking high-pass
// stage after saturation (one extra clk_in cycle of latency).
// ---------------------------------------------------------------------------
module pdm_decimator #(
    parameter int LOG2_DECIM     = 6,
    parameter int WARMUP_SAMPLES = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    pdm_in,
    input  logic                    tick_in,
    pdm_decimator_if.master         o_stream
);

    localparam int W     = 2 * LOG2_DECIM + 2;
    localparam int SHIFT = 2 * LOG2_DECIM - 7;
    localparam int WCW   = (WARMUP_SAMPLES < 1) ? 1 : $clog2(WARMUP_SAMPLES + 1);

    localparam logic signed [W-1:0] SAT_HI = W'(127);
    localparam logic signed [W-1:0] SAT_LO = -(W'(128));

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // CIC state; all registers wrap, the combs cancel the wrap
    logic signed [W-1:0]          r_i1;
    logic signed [W-1:0]          r_i2;
    logic signed [W-1:0]          r_d;
    logic signed [W-1:0]          r_d_prev;
    logic signed [W-1:0]          r_c1_prev;
    logic [LOG2_DECIM-1:0]        r_tick_cnt;
    logic                         r_decim;

    // warm-up control
    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [WCW-1:0]               r_warm_cnt;
    logic [WCW-1:0]               w_warm_nxt;
    logic                         w_deliver;

    // scaled/saturated sample stage
    logic signed [7:0]            r_s;
    logic                         r_s_vld;

    // output register
    logic signed [7:0]            r_sample;
    logic                         r_valid;
    logic                         r_overrun;

    logic signed [W-1:0]          w_x;
    logic                         w_last_tick;
    logic signed [W-1:0]          w_c1;
    logic signed [W-1:0]          w_c2;
    logic signed [W-1:0]          w_scaled;
    logic signed [7:0]            w_sat;
    logic                         w_load;
    logic signed [7:0]            w_load_data;

    assign w_x         = pdm_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    assign w_last_tick = tick_in && (r_tick_cnt == {LOG2_DECIM{1'b1}});

    // Integrators, tick counter and decimation latch
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_i1       <= {W{1'b0}};
            r_i2       <= {W{1'b0}};
            r_d        <= {W{1'b0}};
            r_tick_cnt <= {LOG2_DECIM{1'b0}};
            r_decim    <= 1'b0;
        end else begin
            if (tick_in) begin
                r_i1       <= r_i1 + w_x;
                r_i2       <= r_i2 + r_i1;
                r_tick_cnt <= r_tick_cnt + LOG2_DECIM'(1);
            end
            // r_i2 + r_i1 is the post-update integrator-2 value
            if (w_last_tick) begin
                r_d <= r_i2 + r_i1;
            end
            r_decim <= w_last_tick;
        end
    end

    // Comb differences, scaling and saturation
    always_comb begin
        w_c1     = r_d - r_d_prev;
        w_c2     = w_c1 - r_c1_prev;
        w_scaled = w_c2 >>> SHIFT;
        if (w_scaled > SAT_HI) begin
            w_sat = 8'sd127;
        end else if (w_scaled < SAT_LO) begin
            w_sat = -8'sd128;
        end else begin
            w_sat = w_scaled[7:0];
        end
    end

    // Comb delay registers, advanced once per decimated sample
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_d_prev  <= {W{1'b0}};
            r_c1_prev <= {W{1'b0}};
        end else if (r_decim) begin
            r_d_prev  <= r_d;
            r_c1_prev <= w_c1;
        end
    end

    // Warm-up FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= ST_WARMUP;
            r_warm_cnt <= {WCW{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_nxt;
        end
    end

    // Warm-up FSM next state: discard the first WARMUP_SAMPLES outputs
    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm_cnt;
        w_deliver   = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (r_decim) begin
                    if (r_warm_cnt >= WCW'(WARMUP_SAMPLES)) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_warm_nxt = r_warm_cnt + WCW'(1);
                    end
                end else begin
                    w_state_nxt = ST_WARMUP;
                end
            end
            ST_RUN: begin
                w_deliver = r_decim;
            end
            default: begin
                w_state_nxt = ST_WARMUP;
                w_warm_nxt  = {WCW{1'b0}};
            end
        endcase
    end

    // Scaled-sample pipeline register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s     <= 8'sd0;
            r_s_vld <= 1'b0;
        end else begin
            if (r_decim) begin
                r_s <= w_sat;
            end
            r_s_vld <= w_deliver;
        end
    end

`ifdef PDM_DC_BLOCK_EN
    logic signed [15:0] r_s_prev;
    logic signed [15:0] r_y_prev;
    logic signed [7:0]  r_dc_out;
    logic               r_dc_vld;
    logic signed [15:0] w_s16;
    logic signed [15:0] w_y16;
    logic signed [7:0]  w_y_sat;

    // DC-blocking high-pass: y = s - s_prev + y_prev - y_prev/256
    always_comb begin
        w_s16 = {{8{r_s[7]}}, r_s};
        w_y16 = w_s16 - r_s_prev + r_y_prev - (r_y_prev >>> 8);
        if (w_y16 > 16'sd127) begin
            w_y_sat = 8'sd127;
        end else if (w_y16 < -16'sd128) begin
            w_y_sat = -8'sd128;
        end else begin
            w_y_sat = w_y16[7:0];
        end
    end

    // DC-block history, advanced only on delivered samples
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s_prev <= 16'sd0;
            r_y_prev <= 16'sd0;
            r_dc_out <= 8'sd0;
            r_dc_vld <= 1'b0;
        end else begin
            if (r_s_vld) begin
                r_s_prev <= w_s16;
                r_y_prev <= w_y16;
                r_dc_out <= w_y_sat;
            end
            r_dc_vld <= r_s_vld;
        end
    end

    assign w_load      = r_dc_vld;
    assign w_load_data = r_dc_out;
`else
    assign w_load      = r_s_vld;
    assign w_load_data = r_s;
`endif

    // Output register with overwrite/overrun handling
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sample  <= 8'sd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_sample  <= w_load_data;
                r_valid   <= 1'b1;
                // overwrite of an unconsumed sample unless it is taken on this edge
                r_overrun <= r_valid & ~o_stream.ready_in;
            end else begin
                r_overrun <= 1'b0;
                if (r_valid && o_stream.ready_in) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_stream.sample_out  = r_sample;
    assign o_stream.valid_out   = r_valid;
    assign o_stream.overrun_out = r_overrun;

endmodule

// File: tb/tb_pdm_decimator.sv
// ---------------------------------------------------------------------------
// tb_pdm_decimator
// Randomised and directed stimulus for pdm_decimator (LOG2_DECIM=6). The
// reference model keeps the full history of +/-1 samples and evaluates the
// CIC-2 output in closed form: D(N) = sum_{i<N} x[i]*(N-1-i), and
// c2 = D(N) - 2*D(N-R) + D(N-2R). Expected samples are queued with the clock
// edge on which they must load; a monitor compares output behaviour.
// ---------------------------------------------------------------------------
module tb_pdm_decimator;

    localparam int L  = 6;
    localparam int R  = 1 << L;
    localparam int SH = 2 * L - 7;
    localparam int WS = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic pdm_in;
    logic tick_in;

    pdm_decimator_if u_if();

    pdm_decimator #(.LOG2_DECIM(L), .WARMUP_SAMPLES(WS)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .pdm_in   (pdm_in),
        .tick_in  (tick_in),
        .o_stream (u_if.master)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int value;
        int edge_n;
    } exp_t;

    exp_t sbq[$];
    int   xs[$];
    int   m_warm = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_loads = 0;
    int   n_ovr = 0;
    int   ready_mode = 1;   // 0 random, 1 high, 2 low, 3 high only on a load edge
    bit   mon_en = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint d_of(input int n);
        longint acc = 0;
        for (int i = 0; i < n; i++) acc += longint'(xs[i]) * longint'(n - 1 - i);
        return acc;
    endfunction

    // Record one ticked PDM bit; edge_n is the clock edge that samples it.
    task automatic model_tick(input bit b, input int edge_n);
        longint c2;
        longint s;
        int     n;
        xs.push_back(b ? 1 : -1);
        n = xs.size();
        if (n % R == 0) begin
            c2 = d_of(n) - 2 * d_of(n - R) + d_of(n - 2 * R);
            s  = c2 >>> SH;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            if (m_warm < WS) m_warm++;
            else sbq.push_back('{int'(s), edge_n + 2});
        end
    endtask

    task automatic drive(input bit t, input bit b);
        @(negedge clk_in);
        tick_in = t;
        pdm_in  = b;
        case (ready_mode)
            0: u_if.ready_in = 1'($urandom_range(0, 1));
            1: u_if.ready_in = 1'b1;
            2: u_if.ready_in = 1'b0;
            default: u_if.ready_in = (sbq.size() > 0) && (sbq[0].edge_n == cyc + 1);
        endcase
        if (t) model_tick(b, cyc + 1);
    endtask

    // Monitor: expected handshake state, loads, overrun pulses, held data
    initial begin : monitor
        bit ev;
        bit eo;
        bit load;
        int es;
        ev = 1'b0; eo = 1'b0; es = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_in || !mon_en) begin
                ev = 1'b0;
                eo = 1'b0;
            end else begin
                load = (sbq.size() > 0) && (sbq[0].edge_n == cyc);
                if (load) begin
                    eo = ev && !u_if.ready_in;
                    ev = 1'b1;
                    es = sbq[0].value;
                    void'(sbq.pop_front());
                    n_loads++;
                    if (eo) n_ovr++;
                    check("load_sample", $signed(u_if.sample_out), es);
                end else begin
                    eo = 1'b0;
                    if (ev && u_if.ready_in) ev = 1'b0;
                    if (ev) check("held_sample", $signed(u_if.sample_out), es);
                end
                check("valid_out", u_if.valid_out, ev);
                check("overrun_out", u_if.overrun_out, eo);
            end
        end
    end

    task automatic reset_model();
        sbq.delete();
        xs.delete();
        m_warm = 0;
    endtask

    initial begin : stim
        int e;
        int base_loads;
        int base_ovr;
        bit b;
        rst_in = 1'b1;
        tick_in = 1'b0;
        pdm_in = 1'b0;
        u_if.ready_in = 1'b1;
        @(negedge clk_in);
        check("reset_sample", $signed(u_if.sample_out), 0);
        check("reset_valid", u_if.valid_out, 0);
        check("reset_overrun", u_if.overrun_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        mon_en = 1'b1;

        // constant +1: two suppressed outputs, then full scale
        for (int i = 0; i < 8 * R; i++) drive(1'b1, 1'b1);
        repeat (4) drive(1'b0, 1'b0);
        check("warmup_load_count", n_loads, 6);
        check("full_scale_pos", $signed(u_if.sample_out), 127);
        check("no_overrun_pos", n_ovr, 0);

        // constant -1
        for (int i = 0; i < 6 * R; i++) drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0);
        check("full_scale_neg", $signed(u_if.sample_out), -128);

        // alternating 1,0 with tick every 3rd cycle
        for (int i = 0; i < 4 * R; i++) begin
            drive(1'b1, (i % 2) == 0);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
        end
        repeat (4) drive(1'b0, 1'b0);
        check("alternating_zero", $signed(u_if.sample_out), 0);

        // loopback from a first-order modulator at level 64
        e = 0;
        for (int i = 0; i < 10 * R; i++) begin
            b = (e >= 0);
            e = e + 64 - (b ? 128 : -128);
            drive(1'b1, b);
        end
        repeat (4) drive(1'b0, 1'b0);
        check("loopback_range",
              ($signed(u_if.sample_out) >= 62) && ($signed(u_if.sample_out) <= 66), 1);

        // random bits, random tick spacing, random ready
        ready_mode = 0;
        for (int i = 0; i < 40 * R; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        ready_mode = 1;
        repeat (4) drive(1'b0, 1'b0);

        // ready held low across two loads, then raised on the third load edge
        ready_mode = 2;
        base_loads = n_loads;
        base_ovr = n_ovr;
        for (int i = 0; i < 4 * R && n_loads < base_loads + 2; i++)
            drive(1'b1, 1'($urandom_range(0, 1)));
        check("held_two_loads", n_loads - base_loads, 2);
        check("overrun_once", n_ovr - base_ovr, 1);
        ready_mode = 3;
        for (int i = 0; i < 4 * R && n_loads < base_loads + 3; i++)
            drive(1'b1, 1'($urandom_range(0, 1)));
        check("third_load_seen", n_loads - base_loads, 3);
        check("no_overrun_on_handshake", n_ovr - base_ovr, 1);
        ready_mode = 1;
        repeat (4) drive(1'b0, 1'b0);

        // asynchronous reset mid-window, then warm-up again
        for (int i = 0; i < R / 2; i++) drive(1'b1, 1'($urandom_range(0, 1)));
        @(posedge clk_in);
        #3;
        tick_in = 1'b0;
        rst_in = 1'b1;
        #1;
        check("async_rst_sample", $signed(u_if.sample_out), 0);
        check("async_rst_valid", u_if.valid_out, 0);
        check("async_rst_overrun", u_if.overrun_out, 0);
        reset_model();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        base_loads = n_loads;
        for (int i = 0; i < 5 * R; i++) drive(1'b1, 1'b1);
        repeat (6) drive(1'b0, 1'b0);
        check("post_reset_loads", n_loads - base_loads, 3);
        check("post_reset_value", $signed(u_if.sample_out), 127);
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
